bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 32-bit CPU bus among datapath sources (registers, HI/LO, Z, PC, MDR, ports).

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 123 ++++++++++++
 tb/tb_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin CPU bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN, TURN} arb_state_t;

    localparam logic [31:0] DEF_VALID_MASK = 32'h02FF_FFFF;
    localparam logic [4:0]  DEF_IDLE_SEL   = 5'd31;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests so the pointer sits at bit 0, find the
// lowest set bit, then rotate the offset back into an absolute slot index.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 32,
    parameter int SEL_W   = 5
) (
    input  logic [NUM_REQ-1:0] eff,
    input  logic [SEL_W-1:0]   pointer,
    output logic               found,
    output logic [SEL_W-1:0]   index
);

    localparam logic [SEL_W:0] NREQ = (SEL_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;
    logic [SEL_W:0]       sum;

    assign dbl = {eff, eff} >> pointer;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = SEL_W'(i);
    end

    assign sum   = {1'b0, off} + {1'b0, pointer};
    assign index = (sum >= NREQ) ? SEL_W'(sum - NREQ) : SEL_W'(sum);
    assign found = |eff;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the CPU bus mux; drives the registered select.
// Optional BUS_ARB_TIMEOUT_EN: forcibly release an owner after MAX_HOLD contended cycles.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int                 NUM_REQ    = 32,
    parameter int                 SEL_W      = 5,
    parameter logic [NUM_REQ-1:0] VALID_MASK = DEF_VALID_MASK,
    parameter logic [SEL_W-1:0]   IDLE_SEL   = DEF_IDLE_SEL,
    parameter int                 MAX_HOLD   = 16
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic [SEL_W-1:0]   owner_id,
    output logic               busy,
    output logic               bus_valid,
    output logic               err_req,
    output logic               preempt
);

    localparam int               CNT_W = clog2(MAX_HOLD + 1);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] eff;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] masked_q;
    logic [SEL_W-1:0]   next_ptr;
    logic               owner_req;
    logic               timeout;
    logic               release_own;

    assign eff         = req & VALID_MASK;
    assign masked      = req & ~VALID_MASK;
    assign owner_req   = req[owner_id];
    assign next_ptr    = (owner_id == LAST) ? '0 : owner_id + 1'b1;
    assign release_own = !owner_req || timeout;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             waiting;
    assign waiting = |(eff & ~grant);
    assign timeout = waiting && (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_pick (
        .eff     (eff),
        .pointer (ptr),
        .found   (pick_found),
        .index   (pick_idx)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            grant     <= '0;
            select    <= IDLE_SEL;
            owner_id  <= '0;
            busy      <= 1'b0;
            bus_valid <= 1'b0;
            err_req   <= 1'b0;
            masked_q  <= '0;
            ptr       <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            preempt   <= 1'b0;
`endif
        end else begin
            // mux output is registered, so data follows ownership by one cycle
            bus_valid <= busy;
            masked_q  <= masked;
            err_req   <= |(masked & ~masked_q);
`ifdef BUS_ARB_TIMEOUT_EN
            preempt   <= 1'b0;
`endif
            case (state)
                IDLE, TURN: begin
                    state <= IDLE;
                    if (pick_found) begin
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        select   <= pick_idx;
                        owner_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= OWN;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                OWN: begin
                    // release always passes through TURN so two owners never merge
                    if (release_own) begin
                        grant  <= '0;
                        select <= IDLE_SEL;
                        busy   <= 1'b0;
                        ptr    <= next_ptr;
                        state  <= TURN;
`ifdef BUS_ARB_TIMEOUT_EN
                        preempt  <= owner_req;
                        hold_cnt <= '0;
`endif
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= waiting ? hold_cnt + 1'b1 : '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected owners / error
// pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [31:0] req;
    logic [31:0] grant;
    logic [4:0]  select;
    logic [4:0]  owner_id;
    logic        busy;
    logic        bus_valid;
    logic        err_req;
    logic        preempt;

    localparam logic [31:0] MASK = 32'h02FF_FFFF;

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req       (req),
        .grant     (grant),
        .select    (select),
        .owner_id  (owner_id),
        .busy      (busy),
        .bus_valid (bus_valid),
        .err_req   (err_req),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_q[$];
    logic [31:0] err_q[$];
    bit          rst_seen = 1'b0;
    bit          prev_ok  = 1'b0;
    logic [31:0] prev_grant;
    logic        prev_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] onehot_idx(input logic [31:0] g);
        for (int i = 0; i < 32; i++)
            if (g[i]) return 32'(i);
        return 32'd31;
    endfunction

    always @(negedge clear_n) rst_seen = 1'b1;

    // monitor / scoreboard
    initial begin
        int          e;
        logic [31:0] ee;
        prev_grant = '0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (clear_n === 1'b1) begin
                chk("onehot", 32'($countones(grant) <= 1), 32'd1);
                chk("select_vs_grant", 32'(select), (grant == 0) ? 32'd31 : onehot_idx(grant));
                if (prev_ok && !rst_seen)
                    chk("bus_valid_delay", 32'(bus_valid), 32'(prev_busy));
                if (grant != 0 && grant != prev_grant) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got %0h expected none", grant);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", grant, 32'd1 << e);
                        chk("owner_id", 32'(owner_id), 32'(e));
                    end
                end
                if (err_req) begin
                    if (err_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_err_req: got 1 expected 0");
                    end else begin
                        ee = err_q.pop_front();
                        chk("err_cause", req & ~MASK, ee);
                    end
                end
                prev_ok = 1'b1;
            end else begin
                prev_ok = 1'b0;
            end
            rst_seen   = 1'b0;
            prev_grant = grant;
            prev_busy  = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with all requests high
        clear_n = 1'b0;
        req     = 32'hFFFF_FFFF;
        step(3);
        chk("rst_grant", grant, 32'h0);
        chk("rst_select", 32'(select), 32'd31);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_err", 32'(err_req), 32'd0);
        req     = '0;
        clear_n = 1'b1;
        step(2);

        // 2: single request latency
        req = 32'h20;
        exp_q.push_back(5);
        step();
        chk("t2_grant", grant, 32'h20);
        chk("t2_select", 32'(select), 32'd5);
        chk("t2_bv0", 32'(bus_valid), 32'd0);
        step();
        chk("t2_bv1", 32'(bus_valid), 32'd1);
        req = '0;
        step();
        chk("t2_rel_select", 32'(select), 32'd31);
        chk("t2_rel_bv", 32'(bus_valid), 32'd1);
        step();
        chk("t2_bv_fall", 32'(bus_valid), 32'd0);

        // 3: round robin from pointer 0
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        req = (32'd1 << 2) | (32'd1 << 7) | (32'd1 << 25);
        exp_q.push_back(2);
        exp_q.push_back(7);
        exp_q.push_back(25);
        exp_q.push_back(2);
        step(2);
        foreach (exp_q[k]) begin end
        for (int s = 0; s < 3; s++) begin
            int own;
            own = (s == 0) ? 2 : (s == 1) ? 7 : 25;
            req[own] = 1'b0;
            step();
            chk("t3_turn_select", 32'(select), 32'd31);
            chk("t3_turn_grant", grant, 32'h0);
            req[own] = 1'b1;
            step(2);
        end
        req = '0;
        step(3);

        // 4: masked slot
        req = 32'd1 << 24;
        err_q.push_back(32'd1 << 24);
        step(2);
        chk("t4_masked_grant", grant, 32'h0);
        req = req | 32'd1;
        exp_q.push_back(0);
        step();
        chk("t4_slot0", grant, 32'h1);
        req = '0;
        step(2);
        req = (32'd1 << 26) | (32'd1 << 27) | (32'd1 << 30);
        err_q.push_back(req);
        step(3);
        chk("t4_multi_grant", grant, 32'h0);
        req = '0;
        step(2);

        // 5: contended hold
        req = 32'd1 << 1;
        exp_q.push_back(1);
        step();
        req = req | (32'd1 << 3);
`ifdef BUS_ARB_TIMEOUT_EN
        exp_q.push_back(3);
        step(3);
        chk("t5_no_preempt_yet", 32'(preempt), 32'd0);
        step();
        chk("t5_preempt", 32'(preempt), 32'd1);
        chk("t5_turn_select", 32'(select), 32'd31);
        step();
        chk("t5_new_owner", grant, 32'h8);
`else
        step(30);
        chk("t5_hold", grant, 32'h2);
        chk("t5_preempt_tied", 32'(preempt), 32'd0);
`endif
        req = '0;
        step(3);

        // 6: async reset mid-ownership, then arbitration from pointer 0
        req = 32'd1 << 9;
        exp_q.push_back(9);
        step(2);
        chk("t6_owned", grant, 32'd1 << 9);
        #2 clear_n = 1'b0;
        #1;
        chk("t6_async_grant", grant, 32'h0);
        chk("t6_async_select", 32'(select), 32'd31);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_owner", 32'(owner_id), 32'd0);
        chk("t6_async_bv", 32'(bus_valid), 32'd0);
        req = (32'd1 << 1) | (32'd1 << 9);
        exp_q.push_back(1);
        step(2);
        clear_n = 1'b1;
        step();
        chk("t6_restart", grant, 32'h2);
        req = '0;
        step(4);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("err_q_drained", 32'(err_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
